// File: rtl/fc_pkg.sv
// ---------------------------------------------------------------------------
// fc_pkg - shared buffer-type codes, channel count and scheduler states (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package fc_pkg;

    localparam logic [2:0] FC_PH   = 3'b000;
    localparam logic [2:0] FC_PD   = 3'b001;
    localparam logic [2:0] FC_NPH  = 3'b010;
    localparam logic [2:0] FC_NPD  = 3'b011;
    localparam logic [2:0] FC_CPLH = 3'b100;
    localparam logic [2:0] FC_CPLD = 3'b101;

    localparam int FC_NUM_CH = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } fc_state_e;

endpackage

`default_nettype wire

// File: rtl/fc_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fc_rr_arbiter - combinational round-robin arbiter, search starts at ptr (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module fc_rr_arbiter #(
    parameter int N     = 6,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic found;
    int   j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fc_update_scheduler.sv
// ---------------------------------------------------------------------------
// fc_update_scheduler - UpdateFC advertisement scheduler for six credit buffers (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module fc_update_scheduler
    import fc_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int REFRESH_CYCLES = 1024,
    parameter int MIN_GAP        = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          link_up,
    input  logic [6*(CNT_W+3)-1:0]        fc_limit_i,
    input  logic                          dllp_ready,
    output logic                          dllp_valid,
    output logic [2:0]                    dllp_type,
    output logic [CNT_W-1:0]              dllp_credit,
    output logic [5:0]                    pending_o
);

    localparam int LW    = CNT_W + 3;
    localparam int TMR_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

    fc_state_e                           state_q, state_d;
    logic                                link_q, link_d;
    logic [TMR_W-1:0]                    timer_q, timer_d;
    logic [FC_NUM_CH-1:0]                force_q, force_d;
    logic [FC_NUM_CH-1:0][CNT_W-1:0]     adv_q, adv_d;
    logic [2:0]                          rr_ptr_q, rr_ptr_d;
    logic [3:0]                          gap_q, gap_d;
    logic [2:0]                          type_q, type_d;
    logic [CNT_W-1:0]                    credit_q, credit_d;
    logic [FC_NUM_CH-1:0]                sel_q, sel_d;
    logic [FC_NUM_CH-1:0]                pending_q, pending_d;

    logic [FC_NUM_CH-1:0]                chg;
    logic [FC_NUM_CH-1:0]                pending;
    logic [FC_NUM_CH-1:0]                gnt;
    logic [2:0]                          gnt_idx;
    logic                                expire;
    logic                                accept;
    logic                                arb_ok;
    int                                  base;

    fc_rr_arbiter #(
        .N     (FC_NUM_CH),
        .IDX_W (3)
    ) u_arb (
        .req     (pending),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        for (int i = 0; i < FC_NUM_CH; i++) begin
            chg[i] = (fc_limit_i[i*LW +: CNT_W] != adv_q[i]);
        end
        pending = {FC_NUM_CH{link_up}} & (chg | force_q);
    end

    assign expire = link_up && (timer_q == TMR_W'(REFRESH_CYCLES - 1));
    assign accept = (state_q == SEND) && dllp_ready && link_up;

    always_comb begin
        state_d   = state_q;
        link_d    = link_up;
        timer_d   = timer_q;
        force_d   = force_q;
        adv_d     = adv_q;
        rr_ptr_d  = rr_ptr_q;
        gap_d     = gap_q;
        type_d    = type_q;
        credit_d  = credit_q;
        sel_d     = sel_q;
        pending_d = pending;
        arb_ok    = 1'b0;
        base      = int'(gnt_idx) * LW;

        if (!link_up) begin
            timer_d = '0;
        end else if (expire) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end

        // A refresh or link-up set landing on the accept cycle overrides the clear.
        if (!link_up) begin
            force_d = '0;
        end else begin
            if (accept) begin
                force_d = force_q & ~sel_q;
            end
            if ((link_up && !link_q) || expire) begin
                force_d = '1;
            end
        end

        if (accept) begin
            for (int i = 0; i < FC_NUM_CH; i++) begin
                if (sel_q[i]) begin
                    adv_d[i] = credit_q;
                end
            end
        end

        case (state_q)
            IDLE: arb_ok = 1'b1;
            SEND: begin
                if (dllp_ready) begin
                    state_d = (MIN_GAP == 0) ? IDLE : GAP;
                    gap_d   = '0;
                end
            end
            GAP: begin
                if (gap_q == 4'(MIN_GAP - 1)) begin
                    arb_ok = 1'b1;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The final gap cycle arbitrates directly so back-to-back sends keep MIN_GAP spacing.
        if (arb_ok) begin
            state_d = IDLE;
            if (|pending) begin
                state_d  = SEND;
                type_d   = fc_limit_i[base + CNT_W +: 3];
                credit_d = fc_limit_i[base +: CNT_W];
                sel_d    = gnt;
                rr_ptr_d = (gnt_idx == 3'(FC_NUM_CH - 1)) ? 3'd0 : gnt_idx + 3'd1;
            end
        end

        if (!link_up) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            link_q    <= 1'b0;
            timer_q   <= '0;
            force_q   <= '0;
            adv_q     <= '0;
            rr_ptr_q  <= '0;
            gap_q     <= '0;
            type_q    <= '0;
            credit_q  <= '0;
            sel_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            link_q    <= link_d;
            timer_q   <= timer_d;
            force_q   <= force_d;
            adv_q     <= adv_d;
            rr_ptr_q  <= rr_ptr_d;
            gap_q     <= gap_d;
            type_q    <= type_d;
            credit_q  <= credit_d;
            sel_q     <= sel_d;
            pending_q <= pending_d;
        end
    end

    assign dllp_valid  = (state_q == SEND);
    assign dllp_type   = type_q;
    assign dllp_credit = credit_q;
    assign pending_o   = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_fc_update_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fc_update_scheduler - vector table, corner sequences and random run vs reference model (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fc_update_scheduler;

    localparam int CNT_W   = 8;
    localparam int REFRESH = 64;
    localparam int MIN_GAP = 1;
    localparam int LW      = CNT_W + 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              link_up;
    logic              dllp_ready;
    logic [6*LW-1:0]   fc_limit;
    logic              dllp_valid;
    logic [2:0]        dllp_type;
    logic [CNT_W-1:0]  dllp_credit;
    logic [5:0]        pending_o;

    int n_checks = 0;
    int n_fail   = 0;

    fc_update_scheduler #(
        .CNT_W          (CNT_W),
        .REFRESH_CYCLES (REFRESH),
        .MIN_GAP        (MIN_GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .link_up     (link_up),
        .fc_limit_i  (fc_limit),
        .dllp_ready  (dllp_ready),
        .dllp_valid  (dllp_valid),
        .dllp_type   (dllp_type),
        .dllp_credit (dllp_credit),
        .pending_o   (pending_o)
    );

    always #5 clk = ~clk;

    // Reference model: transaction-level view of the scheduler.
    bit               m_valid;
    logic [2:0]       m_type;
    logic [CNT_W-1:0] m_credit;
    logic [5:0]       m_pend;
    logic [CNT_W-1:0] m_adv [6];
    bit               m_force [6];
    int               m_ptr, m_timer, m_gap, m_sel;
    bit               m_link;

    function automatic logic [CNT_W-1:0] cred(int i);
        logic [6*LW-1:0] v;
        v = fc_limit;
        return v[i*LW +: CNT_W];
    endfunction

    function automatic logic [2:0] typ(int i);
        logic [6*LW-1:0] v;
        v = fc_limit;
        return v[i*LW + CNT_W +: 3];
    endfunction

    task automatic set_limit(int ch, logic [2:0] t, logic [CNT_W-1:0] c);
        fc_limit[ch*LW +: LW] = {t, c};
    endtask

    task automatic model_reset();
        m_valid = 0; m_type = '0; m_credit = '0; m_pend = '0;
        m_ptr = 0; m_timer = 0; m_gap = 0; m_sel = 0; m_link = 0;
        for (int i = 0; i < 6; i++) begin
            m_adv[i]   = '0;
            m_force[i] = 0;
        end
    endtask

    task automatic model_update();
        bit pend [6];
        bit any, rising, expire, accept;
        int g;
        if (rst) begin
            model_reset();
            return;
        end
        any = 0;
        for (int i = 0; i < 6; i++) begin
            pend[i] = link_up && ((cred(i) != m_adv[i]) || m_force[i]);
            m_pend[i] = pend[i];
            any = any | pend[i];
        end
        rising = link_up && !m_link;
        expire = link_up && (m_timer == REFRESH - 1);
        accept = m_valid && dllp_ready && link_up;
        m_timer = (!link_up || expire) ? 0 : m_timer + 1;
        if (accept) m_adv[m_sel] = m_credit;
        for (int i = 0; i < 6; i++) begin
            if (!link_up) m_force[i] = 0;
            else begin
                if (accept && i == m_sel) m_force[i] = 0;
                if (rising || expire) m_force[i] = 1;
            end
        end
        if (!link_up) begin
            m_valid = 0;
            m_gap   = 0;
        end else if (m_valid) begin
            if (dllp_ready) begin
                m_valid = 0;
                m_gap   = MIN_GAP;
            end
        end else if (m_gap > 1) begin
            m_gap = m_gap - 1;
        end else begin
            m_gap = 0;
            if (any) begin
                g = -1;
                for (int k = 0; k < 6; k++) begin
                    if (g < 0 && pend[(m_ptr + k) % 6]) g = (m_ptr + k) % 6;
                end
                m_valid  = 1;
                m_sel    = g;
                m_type   = typ(g);
                m_credit = cred(g);
                m_ptr    = (g + 1) % 6;
            end
        end
        m_link = link_up;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("model_valid", 32'(dllp_valid), 32'(m_valid));
        if (m_valid) begin
            check("model_type", 32'(dllp_type), 32'(m_type));
            check("model_credit", 32'(dllp_credit), 32'(m_credit));
        end
        check("model_pending", 32'(pending_o), 32'(m_pend));
    endtask

    typedef struct {
        bit         link;
        bit         ready;
        bit         exp_valid;
        logic [2:0] exp_type;
        logic [7:0] exp_credit;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int cnt, nv, exp_t;
        logic [CNT_W-1:0] c;

        for (int r = 0; r < 13; r++) begin
            tbl[r].link       = 1;
            tbl[r].ready      = 1;
            tbl[r].exp_valid  = (r % 2 == 0) && (r <= 10);
            tbl[r].exp_type   = 3'(r / 2);
            tbl[r].exp_credit = 8'd16;
        end

        rst = 1; link_up = 1; dllp_ready = 1;
        for (int i = 0; i < 6; i++) set_limit(i, 3'(i), 8'd16);
        model_reset();
        step();
        step();
        check("reset_valid", 32'(dllp_valid), 0);
        check("reset_type", 32'(dllp_type), 0);
        check("reset_credit", 32'(dllp_credit), 0);
        check("reset_pending", 32'(pending_o), 0);

        // Post-link-up burst from the vector table.
        rst = 0;
        for (int r = 0; r < 13; r++) begin
            link_up = tbl[r].link;
            dllp_ready = tbl[r].ready;
            step();
            check("tbl_valid", 32'(dllp_valid), 32'(tbl[r].exp_valid));
            if (tbl[r].exp_valid) begin
                check("tbl_type", 32'(dllp_type), 32'(tbl[r].exp_type));
                check("tbl_credit", 32'(dllp_credit), 32'(tbl[r].exp_credit));
            end
        end

        // Single change with backpressure.
        set_limit(1, 3'd1, 8'd15);
        dllp_ready = 0;
        step();
        check("pd_valid", 32'(dllp_valid), 1);
        check("pd_type", 32'(dllp_type), 1);
        check("pd_credit", 32'(dllp_credit), 15);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_valid", 32'(dllp_valid), 1);
            check("bp_stable", 32'({dllp_type, dllp_credit}), 32'({3'd1, 8'd15}));
        end
        dllp_ready = 1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (dllp_valid) cnt++;
        end
        check("bp_no_dup", 32'(cnt), 0);

        // Round-robin: move pointer to 2, then ch0 and ch3 together.
        set_limit(1, 3'd1, 8'd14);
        step(); step(); step();
        set_limit(0, 3'd0, 8'd20);
        set_limit(3, 3'd3, 8'd21);
        step();
        check("rr_first", 32'({dllp_valid, dllp_type, dllp_credit}), 32'({1'b1, 3'd3, 8'd21}));
        step(); step();
        check("rr_second", 32'({dllp_valid, dllp_type, dllp_credit}), 32'({1'b1, 3'd0, 8'd20}));
        step(); step();
        set_limit(0, 3'd0, 8'd22);
        set_limit(1, 3'd1, 8'd23);
        step();
        check("rr_ptr_end", 32'({dllp_valid, dllp_type}), 32'({1'b1, 3'd1}));
        step(); step();
        check("rr_ptr_next", 32'({dllp_valid, dllp_type}), 32'({1'b1, 3'd0}));
        step(); step();

        // Credit wrap 0xFF -> 0x00.
        set_limit(5, 3'd5, 8'hFF);
        step(); step(); step();
        set_limit(5, 3'd5, 8'h00);
        step();
        check("wrap", 32'({dllp_valid, dllp_type, dllp_credit}), 32'({1'b1, 3'd5, 8'h00}));
        step(); step();

        // Refresh: link bounce, burst, then silence until expiry.
        link_up = 0;
        step(); step();
        check("linkdown_valid", 32'(dllp_valid), 0);
        link_up = 1;
        cnt = 0; nv = 0;
        for (int c0 = 0; c0 < 80; c0++) begin
            step();
            if (c0 >= 12 && c0 < 64 && dllp_valid) cnt++;
            if (c0 >= 64 && dllp_valid) nv++;
            if (c0 == 64) check("refresh_first", 32'({dllp_valid, dllp_type}), 32'({1'b1, 3'd0}));
        end
        check("refresh_quiet", 32'(cnt), 0);
        check("refresh_count", 32'(nv), 6);

        // Async reset mid-SEND, then full burst again.
        set_limit(2, 3'd2, 8'd99);
        dllp_ready = 0;
        step();
        check("pre_rst_valid", 32'(dllp_valid), 1);
        rst = 1;
        #1;
        check("async_rst_valid", 32'(dllp_valid), 0);
        @(negedge clk);
        step();
        rst = 0;
        dllp_ready = 1;
        nv = 0;
        exp_t = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if (dllp_valid) begin
                nv++;
                check("rst_burst_type", 32'(dllp_type), 32'(exp_t));
                exp_t++;
            end
        end
        check("rst_burst_count", 32'(nv), 6);

        // Link drop during SEND.
        set_limit(4, 3'd4, 8'd1);
        dllp_ready = 0;
        step();
        check("pre_drop_valid", 32'(dllp_valid), 1);
        link_up = 0;
        step();
        check("drop_valid", 32'(dllp_valid), 0);
        link_up = 1;
        dllp_ready = 1;

        // Random traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            rst = ($urandom_range(0, 499) == 0);
            if (link_up) link_up = ($urandom_range(0, 149) != 0);
            else         link_up = ($urandom_range(0, 3) == 0);
            dllp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                int ch;
                ch = $urandom_range(0, 5);
                c  = cred(ch);
                if ($urandom_range(0, 1) == 0) c = c + 8'd1;
                else c = 8'($urandom_range(0, 255));
                set_limit(ch, 3'($urandom_range(0, 7)), c);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
